// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game-of-Life grid engine.
package gol_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NBR_W = 4;

  function automatic logic [NBR_W-1:0] nbr_count(input logic [7:0] nbr);
    logic [NBR_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) s = s + NBR_W'(nbr[i]);
    return s;
  endfunction

endpackage

// File: rtl/gol_rule_cell.sv
// One grid cell: programmable birth/survive rule, parallel load, async reset.
module gol_rule_cell
  import gol_pkg::*;
(
  input  logic       CLK,
  input  logic       reset_n,
  input  logic [7:0] nbr,
  input  logic [8:0] rule_birth,
  input  logic [8:0] rule_survive,
  input  logic       upd_en,
  input  logic       load_en,
  input  logic       load_val,
  output logic       state,
  output logic       next_state
);

  logic [NBR_W-1:0] cnt;

  assign cnt        = nbr_count(nbr);
  assign next_state = state ? rule_survive[cnt] : rule_birth[cnt];

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)     state <= 1'b0;
    else if (load_en) state <= load_val;
    else if (upd_en)  state <= next_state;
  end

endmodule

// File: rtl/gol_grid.sv
// ROWS x COLS Game-of-Life array: row load/readback, step handshake,
// early halt on a still generation.
module gol_grid
  import gol_pkg::*;
#(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int WRAP = 1,
  parameter int RW   = $clog2(ROWS)
) (
  input  logic            CLK,
  input  logic            reset_n,
  input  logic [8:0]      rule_birth,
  input  logic [8:0]      rule_survive,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [RW-1:0]   load_row,
  input  logic [COLS-1:0] load_data,
  input  logic            step_valid,
  output logic            step_ready,
  input  logic [15:0]     step_n,
  input  logic            halt_on_still,
  output logic            busy,
  output logic            done,
  output logic            still,
  output logic [31:0]     gen_count,
  input  logic [RW-1:0]   rd_row,
  output logic [COLS-1:0] rd_data
);

  state_t              state;
  logic [15:0]         remaining;
  logic                halt_q;
  logic [COLS-1:0]     grid [ROWS];
  logic [ROWS*COLS-1:0] chg;
  logic                upd_en;
  logic                load_fire;
  logic                any_chg;

  assign load_ready = (state == IDLE);
  assign step_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign upd_en     = (state == RUN);
  assign load_fire  = load_valid && (state == IDLE);
  assign any_chg    = |chg;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nbr;
      logic       cell_q;
      logic       cell_d;

      // k enumerates the 8 neighbours row-major, skipping the centre
      for (genvar k = 0; k < 8; k++) begin : g_nbr
        localparam int DR = (k < 3) ? -1 : (k < 5) ? 0 : 1;
        localparam int DC = (k == 0 || k == 3 || k == 5) ? -1 :
                            (k == 1 || k == 6) ? 0 : 1;
        localparam int RR = r + DR;
        localparam int CC = c + DC;
        localparam bit OUTSIDE = (RR < 0) || (RR >= ROWS) || (CC < 0) || (CC >= COLS);
        localparam int RM = (RR + ROWS) % ROWS;
        localparam int CM = (CC + COLS) % COLS;
        if (WRAP == 0 && OUTSIDE) begin : g_dead
          assign nbr[k] = 1'b0;
        end else begin : g_live
          assign nbr[k] = grid[RM][CM];
        end
      end

      gol_rule_cell u_cell (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .nbr         (nbr),
        .rule_birth  (rule_birth),
        .rule_survive(rule_survive),
        .upd_en      (upd_en),
        .load_en     (load_fire && (int'(load_row) == r)),
        .load_val    (load_data[c]),
        .state       (cell_q),
        .next_state  (cell_d)
      );

      assign grid[r][c]      = cell_q;
      assign chg[r*COLS + c] = cell_d ^ cell_q;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      halt_q    <= 1'b0;
      still     <= 1'b0;
      gen_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (step_valid) begin
            remaining <= step_n;
            halt_q    <= halt_on_still;
            still     <= 1'b0;
            state     <= (step_n == 16'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          gen_count <= gen_count + 32'd1;
          remaining <= remaining - 16'd1;
          still     <= !any_chg;
          if (remaining == 16'd1 || (halt_q && !any_chg)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)                  rd_data <= '0;
    else if (int'(rd_row) < ROWS)  rd_data <= grid[rd_row];
    else                           rd_data <= '0;
  end

endmodule

// File: tb/tb_gol_grid.sv
// Directed bench for gol_grid: toroidal and dead-edge instances driven in parallel.
module tb_gol_grid;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic [8:0]  rule_birth = 9'h008;
  logic [8:0]  rule_survive = 9'h00C;
  logic        load_valid = 1'b0;
  logic [3:0]  load_row = '0;
  logic [15:0] load_data = '0;
  logic        step_valid = 1'b0;
  logic [15:0] step_n = '0;
  logic        halt_on_still = 1'b0;
  logic [3:0]  rd_row = '0;

  logic        load_ready, step_ready, busy, done, still;
  logic [31:0] gen_count;
  logic [15:0] rd_data;
  logic        load_ready_0, step_ready_0, busy_0, done_0, still_0;
  logic [31:0] gen_count_0;
  logic [15:0] rd_data_0;

  always #5 CLK = ~CLK;

  gol_grid #(.ROWS(16), .COLS(16), .WRAP(1)) dut (
    .CLK(CLK), .reset_n(reset_n), .rule_birth(rule_birth), .rule_survive(rule_survive),
    .load_valid(load_valid), .load_ready(load_ready), .load_row(load_row), .load_data(load_data),
    .step_valid(step_valid), .step_ready(step_ready), .step_n(step_n),
    .halt_on_still(halt_on_still), .busy(busy), .done(done), .still(still),
    .gen_count(gen_count), .rd_row(rd_row), .rd_data(rd_data));

  gol_grid #(.ROWS(16), .COLS(16), .WRAP(0)) dut0 (
    .CLK(CLK), .reset_n(reset_n), .rule_birth(rule_birth), .rule_survive(rule_survive),
    .load_valid(load_valid), .load_ready(load_ready_0), .load_row(load_row), .load_data(load_data),
    .step_valid(step_valid), .step_ready(step_ready_0), .step_n(step_n),
    .halt_on_still(halt_on_still), .busy(busy_0), .done(done_0), .still(still_0),
    .gen_count(gen_count_0), .rd_row(rd_row), .rd_data(rd_data_0));

  typedef struct {
    logic [8:0]        birth;
    logic [8:0]        surv;
    int                br;
    logic [0:4][15:0]  init;
    logic [15:0]       n;
    logic              halt;
    logic [0:4][15:0]  exp1;
    logic [0:4][15:0]  exp0;
    int                lat;
    int                dgen;
    logic              st1;
    logic              st0;
  } vec_t;

  vec_t vecs [7];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_gen = 0;

  function automatic vec_t mk(logic [8:0] b, logic [8:0] s, int br, logic [0:4][15:0] init,
                              logic [15:0] n, logic h, logic [0:4][15:0] e1,
                              logic [0:4][15:0] e0, int lat, int dgen, logic s1, logic s0);
    vec_t v;
    v.birth = b; v.surv = s; v.br = br; v.init = init; v.n = n; v.halt = h;
    v.exp1 = e1; v.exp0 = e0; v.lat = lat; v.dgen = dgen; v.st1 = s1; v.st0 = s0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_grid();
    for (int r = 0; r < 16; r++) begin
      load_valid = 1'b1; load_row = 4'(r); load_data = '0;
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 300) begin
      tick();
      lat++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    check("done0_seen", {31'b0, done_0}, 32'd1);
  endtask

  task automatic read_pair(input int row, input logic [15:0] e1, input logic [15:0] e0,
                           input string tag);
    rd_row = 4'(row);
    tick();
    check($sformatf("%s_row%0d_wrap", tag, row), {16'b0, rd_data}, {16'b0, e1});
    check($sformatf("%s_row%0d_dead", tag, row), {16'b0, rd_data_0}, {16'b0, e0});
  endtask

  localparam logic [15:0] Z = 16'h0000;

  initial begin
    int lat;

    vecs[0] = mk(9'h008, 9'h00C, 3, {Z, Z, 16'h0070, Z, Z}, 16'd1, 1'b0,
                 {Z, 16'h0020, 16'h0020, 16'h0020, Z}, {Z, 16'h0020, 16'h0020, 16'h0020, Z},
                 2, 1, 1'b0, 1'b0);
    vecs[1] = mk(9'h008, 9'h00C, 3, {Z, Z, 16'h0070, Z, Z}, 16'd2, 1'b0,
                 {Z, Z, 16'h0070, Z, Z}, {Z, Z, 16'h0070, Z, Z}, 3, 2, 1'b0, 1'b0);
    vecs[2] = mk(9'h008, 9'h00C, 3, {Z, Z, 16'h0030, 16'h0030, Z}, 16'd100, 1'b1,
                 {Z, Z, 16'h0030, 16'h0030, Z}, {Z, Z, 16'h0030, 16'h0030, Z}, 2, 1, 1'b1, 1'b1);
    vecs[3] = mk(9'h008, 9'h00C, 3, {Z, Z, 16'h0070, Z, Z}, 16'd0, 1'b0,
                 {Z, Z, 16'h0070, Z, Z}, {Z, Z, 16'h0070, Z, Z}, 1, 0, 1'b0, 1'b0);
    vecs[4] = mk(9'h008, 9'h00C, 13, {16'h4000, 16'h8000, 16'hE000, Z, Z}, 16'd4, 1'b0,
                 {Z, 16'h8000, 16'h0001, 16'hC001, Z}, {Z, 16'hC000, 16'hC000, Z, Z},
                 5, 4, 1'b0, 1'b1);
    vecs[5] = mk(9'h000, 9'h000, 3, {Z, Z, 16'h0070, Z, Z}, 16'd1, 1'b0,
                 {Z, Z, Z, Z, Z}, {Z, Z, Z, Z, Z}, 2, 1, 1'b0, 1'b0);
    vecs[6] = mk(9'h000, 9'h1FF, 3, {Z, Z, 16'h0070, Z, Z}, 16'd3, 1'b0,
                 {Z, Z, 16'h0070, Z, Z}, {Z, Z, 16'h0070, Z, Z}, 4, 3, 1'b1, 1'b1);

    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_gen", gen_count, 32'd0);
    @(negedge CLK);
    reset_n = 1'b1;
    tick();
    check("init_step_ready", {31'b0, step_ready}, 32'd1);
    check("init_load_ready", {31'b0, load_ready}, 32'd1);
    check("init_still", {31'b0, still}, 32'd0);
    check("init_rd_data", {16'b0, rd_data}, 32'd0);

    foreach (vecs[i]) begin
      rule_birth = vecs[i].birth;
      rule_survive = vecs[i].surv;
      clear_grid();
      for (int k = 0; k < 5; k++) begin
        load_valid = 1'b1;
        load_row = 4'((vecs[i].br + k) % 16);
        load_data = vecs[i].init[k];
        tick();
      end
      load_valid = 1'b0;
      step_valid = 1'b1; step_n = vecs[i].n; halt_on_still = vecs[i].halt;
      tick();
      step_valid = 1'b0;
      wait_done(lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_still_wrap", i), {31'b0, still}, {31'b0, vecs[i].st1});
      check($sformatf("v%0d_still_dead", i), {31'b0, still_0}, {31'b0, vecs[i].st0});
      exp_gen += vecs[i].dgen;
      check($sformatf("v%0d_gen_wrap", i), gen_count, exp_gen);
      check($sformatf("v%0d_gen_dead", i), gen_count_0, exp_gen);
      tick();
      check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
      check($sformatf("v%0d_ready_back", i), {31'b0, step_ready}, 32'd1);
      for (int k = 0; k < 5; k++)
        read_pair((vecs[i].br + k) % 16, vecs[i].exp1[k], vecs[i].exp0[k], $sformatf("v%0d", i));
    end

    // load and step accepted on the same edge
    rule_birth = 9'h008; rule_survive = 9'h00C;
    clear_grid();
    load_valid = 1'b1; load_row = 4'd5; load_data = 16'h0070;
    step_valid = 1'b1; step_n = 16'd1; halt_on_still = 1'b0;
    tick();
    load_valid = 1'b0; step_valid = 1'b0;
    wait_done(lat);
    check("sim_latency", lat, 2);
    exp_gen += 1;
    check("sim_gen", gen_count, exp_gen);
    read_pair(3, Z, Z, "sim");
    read_pair(4, 16'h0020, 16'h0020, "sim");
    read_pair(5, 16'h0020, 16'h0020, "sim");
    read_pair(6, 16'h0020, 16'h0020, "sim");

    // asynchronous reset in the middle of a long run
    clear_grid();
    load_valid = 1'b1; load_row = 4'd5; load_data = 16'h0070;
    tick();
    load_valid = 1'b0;
    step_valid = 1'b1; step_n = 16'd50;
    tick();
    step_valid = 1'b0;
    check("mid_ready_low", {31'b0, step_ready}, 32'd0);
    repeat (10) tick();
    check("mid_gen", gen_count, exp_gen + 10);
    check("mid_busy", {31'b0, busy}, 32'd1);
    rd_row = 4'd5;
    tick();
    check("mid_rd_nonzero", {31'b0, rd_data != 16'h0}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_still", {31'b0, still}, 32'd0);
    check("arst_gen", gen_count, 32'd0);
    check("arst_rd_data", {16'b0, rd_data}, 32'd0);
    exp_gen = 0;
    @(negedge CLK);
    reset_n = 1'b1;
    tick();
    check("rel_step_ready", {31'b0, step_ready}, 32'd1);
    check("rel_load_ready", {31'b0, load_ready}, 32'd1);
    read_pair(4, Z, Z, "rel");
    read_pair(5, Z, Z, "rel");
    read_pair(6, Z, Z, "rel");
    tick();
    check("rel_gen_hold", gen_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
